// File: rtl/frontend_rat_ckpt.sv
// rtl/frontend_rat_ckpt.sv - rename-stage register alias table with branch checkpoint/recovery
module frontend_rat_ckpt #(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHY  = 64,
  parameter int WIDTH    = 2,
  parameter int NUM_CKPT = 4,
  localparam int ARCH_SEL = $clog2(NUM_ARCH),
  localparam int PHY_SEL  = $clog2(NUM_PHY),
  localparam int CK_SEL   = $clog2(NUM_CKPT),
  localparam int LANE_SEL = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [WIDTH*ARCH_SEL-1:0]   rs1,
  input  logic [WIDTH*ARCH_SEL-1:0]   rs2,
  input  logic [WIDTH*ARCH_SEL-1:0]   dst,
  input  logic [WIDTH-1:0]            dst_valid,
  input  logic [WIDTH*PHY_SEL-1:0]    phy_dst,
  input  logic                        ckpt_req,
  input  logic [LANE_SEL-1:0]         ckpt_lane,
  input  logic                        ckpt_release,
  input  logic                        prmiss,
  input  logic [CK_SEL-1:0]           prmiss_tag,
  output logic [WIDTH*PHY_SEL-1:0]    phy_src1,
  output logic [WIDTH*PHY_SEL-1:0]    phy_src2,
  output logic [WIDTH*PHY_SEL-1:0]    phy_ori_dst,
  output logic [CK_SEL-1:0]           ckpt_tag,
  output logic                        ckpt_full,
  output logic                        ckpt_ovf
);

  localparam int CNT_W = CK_SEL + 1;

  typedef logic [PHY_SEL-1:0] phy_t;

  phy_t map      [NUM_ARCH];
  phy_t map_all  [NUM_ARCH];
  phy_t map_snap [NUM_ARCH];
  phy_t slot     [NUM_CKPT][NUM_ARCH];

  logic [CK_SEL-1:0] head, tail, head_n, tail_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              push, pop;

  // Later older lanes overwrite earlier ones, so the youngest older producer wins.
  always_comb begin
    phy_src1    = '0;
    phy_src2    = '0;
    phy_ori_dst = '0;
    for (int j = 0; j < WIDTH; j++) begin
      phy_src1[j*PHY_SEL +: PHY_SEL]    = map[rs1[j*ARCH_SEL +: ARCH_SEL]];
      phy_src2[j*PHY_SEL +: PHY_SEL]    = map[rs2[j*ARCH_SEL +: ARCH_SEL]];
      phy_ori_dst[j*PHY_SEL +: PHY_SEL] = map[dst[j*ARCH_SEL +: ARCH_SEL]];
      for (int i = 0; i < j; i++) begin
        if (dst_valid[i] && (dst[i*ARCH_SEL +: ARCH_SEL] != '0)) begin
          if (dst[i*ARCH_SEL +: ARCH_SEL] == rs1[j*ARCH_SEL +: ARCH_SEL])
            phy_src1[j*PHY_SEL +: PHY_SEL] = phy_dst[i*PHY_SEL +: PHY_SEL];
          if (dst[i*ARCH_SEL +: ARCH_SEL] == rs2[j*ARCH_SEL +: ARCH_SEL])
            phy_src2[j*PHY_SEL +: PHY_SEL] = phy_dst[i*PHY_SEL +: PHY_SEL];
          if (dst[i*ARCH_SEL +: ARCH_SEL] == dst[j*ARCH_SEL +: ARCH_SEL])
            phy_ori_dst[j*PHY_SEL +: PHY_SEL] = phy_dst[i*PHY_SEL +: PHY_SEL];
        end
      end
    end
  end

  // The snapshot only sees writes up to and including the branch lane.
  always_comb begin
    map_all  = map;
    map_snap = map;
    for (int i = 0; i < WIDTH; i++) begin
      if (dst_valid[i] && (dst[i*ARCH_SEL +: ARCH_SEL] != '0)) begin
        map_all[dst[i*ARCH_SEL +: ARCH_SEL]] = phy_dst[i*PHY_SEL +: PHY_SEL];
        if (LANE_SEL'(i) <= ckpt_lane)
          map_snap[dst[i*ARCH_SEL +: ARCH_SEL]] = phy_dst[i*PHY_SEL +: PHY_SEL];
      end
    end
  end

  always_comb begin
    push   = ckpt_req && !ckpt_full && !prmiss;
    pop    = ckpt_release && (count != '0) && !(prmiss && (prmiss_tag == head));
    head_n = head + CK_SEL'(pop);
    if (prmiss) begin
      tail_n  = prmiss_tag;
      count_n = CNT_W'(CK_SEL'(prmiss_tag - head_n));
    end else begin
      tail_n  = tail + CK_SEL'(push);
      count_n = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign ckpt_tag = tail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ARCH; i++) map[i] <= PHY_SEL'(i);
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ckpt_full <= 1'b0;
      ckpt_ovf  <= 1'b0;
    end else begin
      if (prmiss) map <= slot[prmiss_tag];
      else        map <= map_all;
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      ckpt_full <= (count_n == CNT_W'(NUM_CKPT));
      if (ckpt_req && ckpt_full && !prmiss) ckpt_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) slot[tail] <= map_snap;
  end

  // A recovery tag must lie within [head, head+count) measured before any release.
  prmiss_tag_live: assert property (@(posedge clk) disable iff (!reset_n)
    prmiss |-> ((count != '0) && (CNT_W'(CK_SEL'(prmiss_tag - head)) < count)));

endmodule
